// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the parametrised serial sequence detector.
package seq_detect_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  // A pattern length is usable only when it lies in 1..pat_w.
  function automatic logic len_legal(input int unsigned len, input int unsigned pat_w);
    return (len >= 1) && (len <= pat_w);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-sequence detector with run-time pattern/length, overlap mode and match counter.
// Handshake: a bit is consumed on any rising edge where in_valid=1, the FSM is ARMED and cfg_load=0.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter  int PAT_W = 8,
  parameter  int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cnt_clr,
  output logic             armed,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             cfg_err
);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             match_q, match_d;
  logic             err_q, err_d;

  logic [PAT_W-1:0] hist_shift;
  logic [LEN_W-1:0] fill_inc;
  logic [PAT_W-1:0] len_mask;
  logic             hit;

  // Pattern bits at or above len_q are don't-care in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], in_bit};
    fill_inc   = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
    hit        = (fill_inc >= len_q) && (((hist_shift ^ pat_q) & len_mask) == '0);
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    err_d   = 1'b0;
    if (cfg_load) begin
      if (len_legal(32'(pat_len), 32'(PAT_W))) begin
        state_d = ARMED;
        pat_d   = pat;
        len_d   = pat_len;
        ovl_d   = overlap;
        hist_d  = '0;
        fill_d  = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if ((state_q == ARMED) && in_valid) begin
      hist_d  = hist_shift;
      match_d = hit;
      // Non-overlapping mode forces the next match to start from fresh bits.
      fill_d  = (hit && !ovl_q) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match_d),
    .clr   (cnt_clr),
    .count (match_count)
  );

  assign armed   = (state_q == ARMED);
  assign match   = match_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: queue-based reference model, per-cycle expected outputs.
module tb_seq_detect_param;

  localparam int PAT_W = 8;
  localparam int CNT_W = 4;
  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int EW    = 3 + CNT_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] pat = '0;
  logic [LEN_W-1:0] pat_len = '0;
  logic             overlap = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             armed;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             cfg_err;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model state.
  logic       m_armed = 1'b0;
  logic [7:0] m_pat = '0;
  int         m_len = 0;
  logic       m_ovl = 1'b0;
  logic       m_bits[$];
  int         m_cnt = 0;
  logic       m_match = 1'b0;
  logic       m_err = 1'b0;

  seq_detect_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .pat         (pat),
    .pat_len     (pat_len),
    .overlap     (overlap),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .cnt_clr     (cnt_clr),
    .armed       (armed),
    .match       (match),
    .match_count (match_count),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  // Reference: last len accepted bits (oldest first) must spell pat[len-1] .. pat[0].
  task automatic model_step(input logic rst, input logic cl, input logic [7:0] p, input int l,
                            input logic ov, input logic iv, input logic ib, input logic cc);
    logic hit;
    int   n;
    hit = 1'b0;
    if (rst) begin
      m_armed = 1'b0; m_pat = '0; m_len = 0; m_ovl = 1'b0;
      m_bits.delete(); m_cnt = 0; m_match = 1'b0; m_err = 1'b0;
    end else begin
      m_match = 1'b0;
      m_err   = 1'b0;
      if (cl) begin
        if (l >= 1 && l <= PAT_W) begin
          m_armed = 1'b1; m_pat = p; m_len = l; m_ovl = ov;
          m_bits.delete();
        end else begin
          m_err = 1'b1;
        end
      end else if (m_armed && iv) begin
        m_bits.push_back(ib);
        if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
        n = m_bits.size();
        if (n >= m_len) begin
          hit = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (m_bits[n - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
        end
        if (hit) begin
          m_match = 1'b1;
          if (!m_ovl) m_bits.delete();
        end
      end
      if (cc) m_cnt = 0;
      else if (m_match && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
  endtask

  task automatic cycle(input logic rst, input logic cl, input logic [7:0] p, input int l,
                       input logic ov, input logic iv, input logic ib, input logic cc);
    reset = rst; cfg_load = cl; pat = p; pat_len = LEN_W'(l); overlap = ov;
    in_valid = iv; in_bit = ib; cnt_clr = cc;
    @(posedge clk);
    model_step(rst, cl, p, l, ov, iv, ib, cc);
    exp_q.push_back({m_armed, m_match, m_err, CNT_W'(m_cnt)});
    #1;
  endtask

  task automatic feed(input logic b);
    cycle(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input int l, input logic ov);
    cycle(1'b0, 1'b1, p, l, ov, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clr();
    cycle(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_eq(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: one expected record per clock edge, compared at the following falling edge.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("armed", int'(armed), int'(e[EW-1]));
      check_eq("match", int'(match), int'(e[EW-2]));
      check_eq("cfg_err", int'(cfg_err), int'(e[EW-3]));
      check_eq("match_count", int'(match_count), int'(e[CNT_W-1:0]));
    end
  end

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;

    cycle(1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    check_eq("idle_count", int'(match_count), 0);

    // 101 overlapping, upper pattern bits deliberately non-zero.
    load(8'hF5, 3, 1'b1);
    feed(1); feed(0); feed(1); feed(0); feed(1);
    idle();
    check_eq("ovl_count", int'(match_count), 2);

    clr();
    load(8'h05, 3, 1'b0);
    feed(1); feed(0); feed(1); feed(0); feed(1);
    idle();
    check_eq("novl_count", int'(match_count), 1);

    // A5 with 50% valid gaps after a random prefix.
    clr();
    load(a5, 8, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 7; i >= 0; i--) begin
      feed(a5[i]);
      idle();
    end

    // Illegal lengths: rejected, prior A5 config kept.
    load(8'h01, 0, 1'b0);
    load(8'h01, 9, 1'b0);
    load(8'h01, 15, 1'b0);
    for (int i = 7; i >= 0; i--) feed(a5[i]);
    idle();

    // Counter saturation and clear-vs-match priority.
    load(8'h01, 1, 1'b0);
    for (int i = 0; i < 17; i++) feed(1);
    check_eq("sat_count", int'(match_count), 15);
    cycle(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("clr_wins", int'(match_count), 0);
    feed(0); feed(1);

    // Reset mid-stream, then reload and feed only the final bit.
    load(8'h05, 3, 1'b1);
    feed(1); feed(0);
    cycle(1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("armed_after_reset", int'(armed), 0);
    feed(1); feed(1);
    load(8'h05, 3, 1'b1);
    feed(1);
    idle();

    // Random configurations and streams, including load-with-valid and clears.
    for (int r = 0; r < 12; r++) begin
      int l;
      l = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) * $urandom_range(0, 1)
                                      : $urandom_range(1, 4);
      load(8'($urandom), l, 1'($urandom_range(0, 1)));
      for (int c = 0; c < 40; c++) begin
        cycle(1'b0, ($urandom_range(0, 59) == 0), 8'($urandom), $urandom_range(1, 3),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
      end
    end

    @(negedge clk);
    #1;
    check_eq("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
